// File: rtl/quadrature_tdc_decoder_pkg.sv
// Shared types and the Johnson-code decoder for the quadrature TDC receive path.
package tdc_pkg;

    typedef logic [2:0] fine_t;

    typedef struct packed {
        fine_t fine;
        logic  bubble;
    } dec_t;

    // Johnson codes {s135,s90,s45,s0} for fine bins 0..7.
    localparam logic [3:0] CODE_F0 = 4'b0001;
    localparam logic [3:0] CODE_F1 = 4'b0011;
    localparam logic [3:0] CODE_F2 = 4'b0111;
    localparam logic [3:0] CODE_F3 = 4'b1111;
    localparam logic [3:0] CODE_F4 = 4'b1110;
    localparam logic [3:0] CODE_F5 = 4'b1100;
    localparam logic [3:0] CODE_F6 = 4'b1000;
    localparam logic [3:0] CODE_F7 = 4'b0000;

    // Invalid codes decode to bin 0 with the bubble flag raised.
    function automatic dec_t johnson_decode(input logic [3:0] code);
        dec_t d;
        d.fine   = 3'd0;
        d.bubble = 1'b0;
        case (code)
            CODE_F0: d.fine = 3'd0;
            CODE_F1: d.fine = 3'd1;
            CODE_F2: d.fine = 3'd2;
            CODE_F3: d.fine = 3'd3;
            CODE_F4: d.fine = 3'd4;
            CODE_F5: d.fine = 3'd5;
            CODE_F6: d.fine = 3'd6;
            CODE_F7: d.fine = 3'd7;
            default: d.bubble = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/quadrature_tdc_decoder_if.sv
// Timestamp readout stream (valid/ready) between the decoder and the DAQ.
interface quadrature_tdc_decoder_if #(
    parameter int TS_W = 19
);
    logic [TS_W-1:0] o_ts_data;
    logic            o_ts_valid;
    logic            i_ts_ready;

    modport master (output o_ts_data, output o_ts_valid, input  i_ts_ready);
    modport slave  (input  o_ts_data, input  o_ts_valid, output i_ts_ready);
endinterface

// File: rtl/quadrature_tdc_decoder_fifo.sv
// Synchronous timestamp FIFO; head is read straight from the storage registers.
module tdc_ts_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop_ok, push_ok;

    assign pop_ok  = pop & (count != '0);
    assign push_ok = push & ((count != (AW+1)'(DEPTH)) | pop_ok);

    // Pointer and occupancy bookkeeping; clear and reset discard pending operations.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; on full with a pop the slot being freed is the one written.
    always_ff @(posedge clk) begin
        if (push_ok && !reset && !clr) mem[wr_ptr] <= din;
    end

    assign valid = (count != '0);
    assign dout  = valid ? mem[rd_ptr] : '0;
    assign level = count;
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/quadrature_tdc_decoder.sv
// Quadrature TDC receive end: coarse counter, Johnson fine decode, hit accept, error stats.
module quadrature_tdc_decoder
    import tdc_pkg::*;
#(
    parameter int COARSE_W = 16,
    parameter int DEPTH    = 8,
    parameter int SYNC_LAT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_enable,
    input  logic                      i_clear,
    input  logic                      i_hit_valid,
    input  logic [3:0]                i_phase_sample,
    quadrature_tdc_decoder_if.master  ts_if,
    output logic [$clog2(DEPTH):0]    o_fifo_level,
    output logic                      o_overflow,
    output logic [ERR_W-1:0]          o_bubble_cnt,
    output logic [ERR_W-1:0]          o_drop_cnt
);
    typedef struct packed {
        logic [COARSE_W-1:0] coarse;
        fine_t               fine;
    } ts_t;

    logic [COARSE_W-1:0] coarse;
    dec_t                dec;
    ts_t                 ts_new;
    logic                accept, pop, full, push, drop;

    assign dec           = johnson_decode(i_phase_sample);
    assign ts_new.coarse = coarse - COARSE_W'(SYNC_LAT);
    assign ts_new.fine   = dec.fine;

    assign accept = i_hit_valid & i_enable & ~reset & ~i_clear;
    assign pop    = ts_if.o_ts_valid & ts_if.i_ts_ready;
    assign push   = accept & (~full | pop);
    assign drop   = accept & full & ~pop;

    // Free-running coarse time base, independent of i_enable.
    always_ff @(posedge clk) begin
        if (reset || i_clear) coarse <= '0;
        else                  coarse <= coarse + COARSE_W'(1);
    end

    // Sticky overflow and saturating bubble/drop statistics.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            o_overflow   <= 1'b0;
            o_bubble_cnt <= '0;
            o_drop_cnt   <= '0;
        end else begin
            if (drop) o_overflow <= 1'b1;
            if (accept && dec.bubble && o_bubble_cnt != '1)
                o_bubble_cnt <= o_bubble_cnt + ERR_W'(1);
            if (drop && o_drop_cnt != '1)
                o_drop_cnt <= o_drop_cnt + ERR_W'(1);
        end
    end

    tdc_ts_fifo #(
        .W     (COARSE_W + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (i_clear),
        .push  (push),
        .din   (ts_new),
        .pop   (pop),
        .dout  (ts_if.o_ts_data),
        .valid (ts_if.o_ts_valid),
        .level (o_fifo_level),
        .full  (full)
    );

endmodule

// File: tb/tb_quadrature_tdc_decoder.sv
// Directed bench for quadrature_tdc_decoder (COARSE_W=4 so wrap cases are quick to reach).
module tb_quadrature_tdc_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_enable;
    logic       i_clear;
    logic       i_hit_valid;
    logic [3:0] i_phase_sample;
    logic [3:0] o_fifo_level;
    logic       o_overflow;
    logic [7:0] o_bubble_cnt;
    logic [7:0] o_drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] model_cnt;
    logic [6:0] expq[$];

    quadrature_tdc_decoder_if #(.TS_W(7)) ts_if ();

    quadrature_tdc_decoder #(
        .COARSE_W (4),
        .DEPTH    (8),
        .SYNC_LAT (2),
        .ERR_W    (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (i_enable),
        .i_clear        (i_clear),
        .i_hit_valid    (i_hit_valid),
        .i_phase_sample (i_phase_sample),
        .ts_if          (ts_if.master),
        .o_fifo_level   (o_fifo_level),
        .o_overflow     (o_overflow),
        .o_bubble_cnt   (o_bubble_cnt),
        .o_drop_cnt     (o_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference time base: value of the coarse counter during the current cycle.
    always @(posedge clk) begin
        if (reset || i_clear) model_cnt <= 4'd0;
        else                  model_cnt <= model_cnt + 4'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
    endtask

    // One-cycle hit; returns the timestamp the decoder should record for it.
    task automatic drive_hit(input logic [3:0] code, input logic [2:0] fine, output logic [6:0] exp);
        i_hit_valid    = 1'b1;
        i_phase_sample = code;
        exp            = {model_cnt - 4'd2, fine};
        step();
        i_hit_valid    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total_cnt++;
        if (ts_if.o_ts_valid !== 1'b0 || ts_if.o_ts_data !== 7'd0 || o_fifo_level !== 4'd0 ||
            o_overflow !== 1'b0 || o_bubble_cnt !== 8'd0 || o_drop_cnt !== 8'd0)
            $display("FAIL reset_state: valid=%b data=%h level=%0d ovf=%b bub=%0d drop=%0d, required all zero",
                     ts_if.o_ts_valid, ts_if.o_ts_data, o_fifo_level, o_overflow, o_bubble_cnt, o_drop_cnt);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [3:0] codes [8];
        logic [6:0] exp;
        codes = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        ts_if.i_ts_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_hit(codes[i], 3'(i), exp);
            total_cnt++;
            if (ts_if.o_ts_valid !== 1'b1 || ts_if.o_ts_data !== exp)
                $display("FAIL sweep_fine%0d: valid=%b data=%h, required valid=1 data=%h",
                         i, ts_if.o_ts_valid, ts_if.o_ts_data, exp);
            else pass_cnt++;
            step();
            total_cnt++;
            if (ts_if.o_ts_valid !== 1'b0 || o_fifo_level !== 4'd0)
                $display("FAIL sweep_pop%0d: valid=%b level=%0d, required 0 and 0", i, ts_if.o_ts_valid, o_fifo_level);
            else pass_cnt++;
        end
        total_cnt++;
        if (o_bubble_cnt !== 8'd0)
            $display("FAIL sweep_bubble: bubble_cnt=%0d, required 0", o_bubble_cnt);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        logic [6:0] exp;
        ts_if.i_ts_ready = 1'b1;
        drive_hit(4'b0101, 3'd0, exp);
        total_cnt++;
        if (ts_if.o_ts_valid !== 1'b1 || ts_if.o_ts_data !== exp || o_bubble_cnt !== 8'd1)
            $display("FAIL bubble_0101: valid=%b data=%h bub=%0d, required 1 %h 1",
                     ts_if.o_ts_valid, ts_if.o_ts_data, o_bubble_cnt, exp);
        else pass_cnt++;
        step();
        drive_hit(4'b1010, 3'd0, exp);
        total_cnt++;
        if (ts_if.o_ts_data !== exp || o_bubble_cnt !== 8'd2)
            $display("FAIL bubble_1010: data=%h bub=%0d, required %h 2", ts_if.o_ts_data, o_bubble_cnt, exp);
        else pass_cnt++;
        step();
    endtask

    task automatic test_full_and_simultaneous();
        logic [6:0] exp;
        logic [6:0] head;
        do_clear();
        expq.delete();
        ts_if.i_ts_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_hit(4'b0011, 3'd1, exp);
            if (i < 8) expq.push_back(exp);
        end
        total_cnt++;
        if (o_fifo_level !== 4'd8 || o_overflow !== 1'b1 || o_drop_cnt !== 8'd1)
            $display("FAIL full: level=%0d ovf=%b drop=%0d, required 8 1 1", o_fifo_level, o_overflow, o_drop_cnt);
        else pass_cnt++;
        head = expq.pop_front();
        total_cnt++;
        if (ts_if.o_ts_data !== head)
            $display("FAIL full_head: data=%h, required %h", ts_if.o_ts_data, head);
        else pass_cnt++;
        ts_if.i_ts_ready = 1'b1;
        drive_hit(4'b1100, 3'd5, exp);
        ts_if.i_ts_ready = 1'b0;
        expq.push_back(exp);
        total_cnt++;
        if (o_fifo_level !== 4'd8 || o_drop_cnt !== 8'd1)
            $display("FAIL simultaneous: level=%0d drop=%0d, required 8 1", o_fifo_level, o_drop_cnt);
        else pass_cnt++;
        ts_if.i_ts_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = expq.pop_front();
            total_cnt++;
            if (ts_if.o_ts_valid !== 1'b1 || ts_if.o_ts_data !== exp)
                $display("FAIL drain%0d: valid=%b data=%h, required 1 %h", i, ts_if.o_ts_valid, ts_if.o_ts_data, exp);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (ts_if.o_ts_valid !== 1'b0 || o_fifo_level !== 4'd0)
            $display("FAIL drain_empty: valid=%b level=%0d, required 0 0", ts_if.o_ts_valid, o_fifo_level);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [6:0] exp;
        int n;
        do_clear();
        ts_if.i_ts_ready = 1'b1;
        n = 0;
        while (model_cnt != 4'd1 && n < 40) begin step(); n++; end
        drive_hit(4'b1111, 3'd3, exp);
        total_cnt++;
        if (ts_if.o_ts_data !== 7'b1111_011)
            $display("FAIL wrap_cnt1: data=%h, required %h", ts_if.o_ts_data, 7'b1111_011);
        else pass_cnt++;
        step();
        n = 0;
        while (model_cnt != 4'd0 && n < 40) begin step(); n++; end
        drive_hit(4'b0000, 3'd7, exp);
        total_cnt++;
        if (ts_if.o_ts_data !== 7'b1110_111)
            $display("FAIL wrap_cnt0: data=%h, required %h", ts_if.o_ts_data, 7'b1110_111);
        else pass_cnt++;
        step();
    endtask

    task automatic test_enable();
        logic [6:0] exp;
        logic [6:0] ign;
        do_clear();
        ts_if.i_ts_ready = 1'b0;
        drive_hit(4'b0111, 3'd2, exp);
        i_enable = 1'b0;
        drive_hit(4'b1000, 3'd6, ign);
        drive_hit(4'b0101, 3'd0, ign);
        total_cnt++;
        if (o_fifo_level !== 4'd1 || o_drop_cnt !== 8'd0 || o_bubble_cnt !== 8'd0 || ts_if.o_ts_data !== exp)
            $display("FAIL enable_off: level=%0d drop=%0d bub=%0d data=%h, required 1 0 0 %h",
                     o_fifo_level, o_drop_cnt, o_bubble_cnt, ts_if.o_ts_data, exp);
        else pass_cnt++;
        ts_if.i_ts_ready = 1'b1;
        step();
        total_cnt++;
        if (ts_if.o_ts_valid !== 1'b0)
            $display("FAIL enable_drain: valid=%b, required 0", ts_if.o_ts_valid);
        else pass_cnt++;
        i_enable = 1'b1;
    endtask

    task automatic test_backpressure_clear();
        logic [6:0] exp;
        logic [6:0] ign;
        do_clear();
        ts_if.i_ts_ready = 1'b0;
        drive_hit(4'b1110, 3'd4, exp);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (ts_if.o_ts_valid !== 1'b1 || ts_if.o_ts_data !== exp)
                $display("FAIL hold%0d: valid=%b data=%h, required 1 %h", i, ts_if.o_ts_valid, ts_if.o_ts_data, exp);
            else pass_cnt++;
            step();
        end
        drive_hit(4'b0101, 3'd0, ign);
        for (int i = 0; i < 7; i++) drive_hit(4'b0001, 3'd0, ign);
        total_cnt++;
        if (o_fifo_level !== 4'd8 || o_overflow !== 1'b1 || o_drop_cnt !== 8'd1 || o_bubble_cnt !== 8'd1)
            $display("FAIL preclear: level=%0d ovf=%b drop=%0d bub=%0d, required 8 1 1 1",
                     o_fifo_level, o_overflow, o_drop_cnt, o_bubble_cnt);
        else pass_cnt++;
        i_clear          = 1'b1;
        ts_if.i_ts_ready = 1'b1;
        i_hit_valid      = 1'b1;
        step();
        i_clear     = 1'b0;
        i_hit_valid = 1'b0;
        total_cnt++;
        if (o_fifo_level !== 4'd0 || ts_if.o_ts_valid !== 1'b0 || ts_if.o_ts_data !== 7'd0 ||
            o_overflow !== 1'b0 || o_drop_cnt !== 8'd0 || o_bubble_cnt !== 8'd0)
            $display("FAIL clear: level=%0d valid=%b data=%h ovf=%b drop=%0d bub=%0d, required all zero",
                     o_fifo_level, ts_if.o_ts_valid, ts_if.o_ts_data, o_overflow, o_drop_cnt, o_bubble_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [6:0] ign;
        do_clear();
        ts_if.i_ts_ready = 1'b1;
        for (int i = 0; i < 260; i++) drive_hit(4'b1010, 3'd0, ign);
        step();
        total_cnt++;
        if (o_bubble_cnt !== 8'd255 || o_drop_cnt !== 8'd0)
            $display("FAIL bubble_saturate: bub=%0d drop=%0d, required 255 0", o_bubble_cnt, o_drop_cnt);
        else pass_cnt++;
    endtask

    initial begin
        reset            = 1'b1;
        i_enable         = 1'b1;
        i_clear          = 1'b0;
        i_hit_valid      = 1'b0;
        i_phase_sample   = 4'd0;
        ts_if.i_ts_ready = 1'b0;
        test_reset();
        step();
        step();
        test_sweep();
        test_bubble();
        test_full_and_simultaneous();
        test_wrap();
        test_enable();
        test_backpressure_clear();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
